// File: rtl/bpred_update_buffer_pkg.sv
// Shared configuration for the branch-predictor update path.
package bpred_update_buffer_pkg;

  typedef struct packed {
    int unsigned xlen;
    int unsigned pht_k;
    int unsigned upd_depth;
  } cvw_t;

  localparam cvw_t CvwDefault = '{xlen: 32, pht_k: 10, upd_depth: 4};

endpackage

// File: rtl/bpred_update_buffer_satcnt2.sv
// 2-bit saturating direction counter: taken counts up, not-taken counts down.
module bpred_update_buffer_satcnt2 (
  input  logic [1:0] state_i,
  input  logic       taken_i,
  output logic [1:0] state_o
);

  always_comb begin
    state_o = state_i;
    if (taken_i && (state_i != 2'b11)) begin
      state_o = state_i + 2'd1;
    end else if (!taken_i && (state_i != 2'b00)) begin
      state_o = state_i - 2'd1;
    end
  end

endmodule

// File: rtl/bpred_update_buffer.sv
// Coalescing write buffer between resolved branches and the PHT write port,
// with forwarding of pending/just-written counters to the fetch-side read.
module bpred_update_buffer
  import bpred_update_buffer_pkg::*;
#(
  parameter cvw_t        P     = CvwDefault,
  parameter int unsigned XLEN  = P.xlen,
  parameter int unsigned k     = P.pht_k,
  parameter int unsigned DEPTH = P.upd_depth
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            BranchM,
  input  logic            PCSrcM,
  input  logic [1:0]      BPDirPredM,
  input  logic [XLEN-1:0] PCM,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [1:0]      PHTRdDataF,
  output logic [1:0]      BPDirPredF,
  input  logic            PHTWrReady,
  output logic            PHTWrEn,
  output logic [k-1:0]    PHTWrIndex,
  output logic [1:0]      PHTWrState,
  output logic            UpdDroppedM
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic         valid;
    logic [k-1:0] idx;
    logic [1:0]   state;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d, match_ptr;
  logic [CntW-1:0]  count_q, count_d;
  logic [k-1:0]     enq_idx, rd_idx, idxf_q, idxf_d;
  logic             lastwr_v_q, lastwr_v_d;
  logic [k-1:0]     lastwr_idx_q, lastwr_idx_d;
  logic [1:0]       lastwr_state_q, lastwr_state_d;
  logic             enq, drain, full, match, head_hit, coalesce, alloc;
  logic [1:0]       base_state, alloc_state, coal_state;
  logic             fwd_hit;
  logic [1:0]       fwd_state;
  logic             unused_pc;

  assign enq_idx   = {PCM[k+1] ^ PCM[1], PCM[k:2]};
  assign rd_idx    = {PCNextF[k+1] ^ PCNextF[1], PCNextF[k:2]};
  assign unused_pc = ^{PCM[XLEN-1:k+2], PCM[0], PCNextF[XLEN-1:k+2], PCNextF[0]};

  assign enq   = BranchM & ~StallM & ~FlushM;
  assign drain = (count_q != '0) & PHTWrReady & ~reset;
  assign full  = (count_q == CntW'(DEPTH));

  // At most one valid entry per index, so the last hit is the only hit.
  always_comb begin
    match     = 1'b0;
    match_ptr = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].idx == enq_idx)) begin
        match     = 1'b1;
        match_ptr = PtrW'(i);
      end
    end
  end

  // A hit on the head that is leaving this cycle re-allocates, seeded with its state.
  assign head_hit    = match & drain & (match_ptr == head_q);
  assign coalesce    = enq & match & ~head_hit;
  assign alloc       = enq & ~coalesce & (~full | drain);
  assign UpdDroppedM = enq & ~coalesce & full & ~drain & ~reset;
  assign base_state  = head_hit ? ent_q[head_q].state : BPDirPredM;

  bpred_update_buffer_satcnt2 u_enq_cnt (
    .state_i (base_state),
    .taken_i (PCSrcM),
    .state_o (alloc_state)
  );

  bpred_update_buffer_satcnt2 u_coal_cnt (
    .state_i (ent_q[match_ptr].state),
    .taken_i (PCSrcM),
    .state_o (coal_state)
  );

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (drain) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PtrW'(1);
    end
    if (coalesce) begin
      ent_d[match_ptr].state = coal_state;
    end
    if (alloc) begin
      ent_d[tail_q] = '{valid: 1'b1, idx: enq_idx, state: alloc_state};
      tail_d        = tail_q + PtrW'(1);
    end
    count_d = count_q + CntW'(alloc) - CntW'(drain);
  end

  assign PHTWrEn    = drain;
  assign PHTWrIndex = ent_q[head_q].idx;
  assign PHTWrState = ent_q[head_q].state;

  assign lastwr_v_d     = drain;
  assign lastwr_idx_d   = ent_q[head_q].idx;
  assign lastwr_state_d = ent_q[head_q].state;
  assign idxf_d         = StallF ? idxf_q : rd_idx;

  // Forwarding uses buffer contents as of the start of the cycle.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_state = 2'b00;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].idx == idxf_q)) begin
        fwd_hit   = 1'b1;
        fwd_state = ent_q[i].state;
      end
    end
    BPDirPredF = PHTRdDataF;
    if (!reset) begin
      if (fwd_hit) begin
        BPDirPredF = fwd_state;
      end else if (lastwr_v_q && (lastwr_idx_q == idxf_q)) begin
        BPDirPredF = lastwr_state_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      lastwr_v_q     <= 1'b0;
      lastwr_idx_q   <= '0;
      lastwr_state_q <= 2'b00;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      lastwr_v_q     <= lastwr_v_d;
      lastwr_idx_q   <= lastwr_idx_d;
      lastwr_state_q <= lastwr_state_d;
    end
  end

  always_ff @(posedge clk) begin
    idxf_q <= idxf_d;
  end

endmodule

// File: tb/tb_bpred_update_buffer.sv
// Bench for bpred_update_buffer: directed vector table, hand sequences and
// random traffic checked against a queue-based model of the update buffer.
module tb_bpred_update_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, StallF, StallM, FlushM, BranchM, PCSrcM;
  logic [1:0]  BPDirPredM, PHTRdDataF, BPDirPredF, PHTWrState;
  logic [31:0] PCM, PCNextF;
  logic        PHTWrReady, PHTWrEn, UpdDroppedM;
  logic [9:0]  PHTWrIndex;

  always #5 clk = ~clk;

  bpred_update_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallM      (StallM),
    .FlushM      (FlushM),
    .BranchM     (BranchM),
    .PCSrcM      (PCSrcM),
    .BPDirPredM  (BPDirPredM),
    .PCM         (PCM),
    .PCNextF     (PCNextF),
    .PHTRdDataF  (PHTRdDataF),
    .BPDirPredF  (BPDirPredF),
    .PHTWrReady  (PHTWrReady),
    .PHTWrEn     (PHTWrEn),
    .PHTWrIndex  (PHTWrIndex),
    .PHTWrState  (PHTWrState),
    .UpdDroppedM (UpdDroppedM)
  );

  typedef struct {
    logic [9:0] idx;
    logic [1:0] st;
  } mentry_t;

  typedef struct {
    logic        rst, br, tk;
    logic [1:0]  pr;
    logic [31:0] pc;
    logic        rdy, stm, flm;
    logic [31:0] pcn;
    logic [1:0]  rd;
    logic        ewr;
    logic [9:0]  eidx;
    logic [1:0]  est;
    logic        edrop;
    logic [1:0]  epf;
  } vec_t;

  mentry_t    mq[$];
  logic       lw_v = 1'b0;
  logic [9:0] lw_idx = '0;
  logic [1:0] lw_st = '0;
  logic [9:0] m_idxf = '0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       s_wren, s_drop;
  logic [9:0] s_idx;
  logic [1:0] s_st, s_pf;
  vec_t       vecs[$];

  function automatic logic [9:0] hash(input logic [31:0] pc);
    return {pc[11] ^ pc[1], pc[10:2]};
  endfunction

  function automatic logic [1:0] sat2(input logic [1:0] s, input logic t);
    int v;
    v = int'(s) + (t ? 1 : -1);
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    return 2'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic br, input logic tk, input logic [1:0] pr,
                        input logic [31:0] pc, input logic rdy);
    reset = 1'b0; StallF = 1'b0; StallM = 1'b0; FlushM = 1'b0;
    BranchM = br; PCSrcM = tk; BPDirPredM = pr; PCM = pc; PHTWrReady = rdy;
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the model.
  task automatic tick();
    bit         enq, drained, found;
    int         fi;
    logic       e_wren, e_drop;
    logic [9:0] e_idx, h;
    logic [1:0] e_st, e_pf;
    mentry_t    popped;
    @(negedge clk);
    enq     = BranchM && !StallM && !FlushM;
    drained = !reset && (mq.size() > 0) && PHTWrReady;
    h       = hash(PCM);
    e_wren  = drained;
    e_idx   = (mq.size() > 0) ? mq[0].idx : '0;
    e_st    = (mq.size() > 0) ? mq[0].st : '0;
    found   = 0;
    for (int i = drained ? 1 : 0; i < mq.size(); i++) if (mq[i].idx == h) found = 1;
    e_drop = !reset && enq && !found && (mq.size() == DEPTH) && !drained;
    e_pf   = PHTRdDataF;
    if (!reset) begin
      fi = -1;
      for (int i = 0; i < mq.size(); i++) if (mq[i].idx == m_idxf) fi = i;
      if (fi >= 0) e_pf = mq[fi].st;
      else if (lw_v && lw_idx == m_idxf) e_pf = lw_st;
    end
    s_wren = PHTWrEn; s_drop = UpdDroppedM; s_idx = PHTWrIndex; s_st = PHTWrState;
    s_pf   = BPDirPredF;
    check("model PHTWrEn", s_wren, e_wren);
    if (e_wren) begin
      check("model PHTWrIndex", s_idx, e_idx);
      check("model PHTWrState", s_st, e_st);
    end
    check("model UpdDroppedM", s_drop, e_drop);
    check("model BPDirPredF", s_pf, e_pf);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      lw_v = 0;
    end else begin
      lw_v = e_wren; lw_idx = e_idx; lw_st = e_st;
      popped = '{idx: '0, st: '0};
      if (drained) popped = mq.pop_front();
      if (enq) begin
        fi = -1;
        for (int i = 0; i < mq.size(); i++) if (mq[i].idx == h) fi = i;
        if (fi >= 0) mq[fi].st = sat2(mq[fi].st, PCSrcM);
        else if (mq.size() < DEPTH)
          mq.push_back('{idx: h, st: sat2((drained && popped.idx == h) ? popped.st : BPDirPredM,
                                          PCSrcM)});
      end
    end
    if (!StallF) m_idxf = hash(PCNextF);
    #1;
  endtask

  initial begin
    int         nwr;
    logic [9:0] exp_order[4];
    reset = 1'b1; StallF = 0; StallM = 0; FlushM = 0; BranchM = 0; PCSrcM = 0;
    BPDirPredM = 0; PCM = 0; PCNextF = 0; PHTRdDataF = 2'b10; PHTWrReady = 0;

    // rst br tk pr pc rdy stm flm pcn rd | ewr eidx est edrop epf
    vecs.push_back('{1, 0, 0, 0, 32'h000, 0, 0, 0, 32'h000, 2, 0, 10'h000, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h000, 2, 0, 10'h000, 0, 0, 2});
    vecs.push_back('{0, 1, 1, 1, 32'h100, 1, 0, 0, 32'h000, 2, 0, 10'h000, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h000, 2, 1, 10'h040, 2, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h000, 2, 0, 10'h000, 0, 0, 2});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{0, 1, 1, 0, 32'h200, 0, 0, 0, 32'h000, 2, 0, 10'h000, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h000, 2, 1, 10'h080, 3, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h000, 2, 0, 10'h000, 0, 0, 2});
    vecs.push_back('{0, 1, 0, 1, 32'h100, 0, 0, 0, 32'h100, 3, 0, 10'h000, 0, 0, 3});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h100, 3, 0, 10'h000, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h100, 3, 1, 10'h040, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h100, 3, 0, 10'h000, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h100, 3, 0, 10'h000, 0, 0, 3});
    vecs.push_back('{0, 1, 1, 1, 32'h300, 1, 1, 0, 32'h100, 3, 0, 10'h000, 0, 0, 3});
    vecs.push_back('{0, 1, 1, 1, 32'h300, 1, 0, 1, 32'h000, 3, 0, 10'h000, 0, 0, 3});
    vecs.push_back('{0, 0, 0, 0, 32'h000, 1, 0, 0, 32'h000, 3, 0, 10'h000, 0, 0, 3});

    foreach (vecs[i]) begin
      reset = vecs[i].rst; BranchM = vecs[i].br; PCSrcM = vecs[i].tk; BPDirPredM = vecs[i].pr;
      PCM = vecs[i].pc; PHTWrReady = vecs[i].rdy; StallM = vecs[i].stm; FlushM = vecs[i].flm;
      PCNextF = vecs[i].pcn; PHTRdDataF = vecs[i].rd; StallF = 0;
      tick();
      check($sformatf("vec%0d wren", i), s_wren, vecs[i].ewr);
      if (vecs[i].ewr) begin
        check($sformatf("vec%0d widx", i), s_idx, vecs[i].eidx);
        check($sformatf("vec%0d wstate", i), s_st, vecs[i].est);
      end
      check($sformatf("vec%0d drop", i), s_drop, vecs[i].edrop);
      check($sformatf("vec%0d predF", i), s_pf, vecs[i].epf);
    end

    // Fill all entries, overflow once, then overflow again while draining.
    PCNextF = 0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 1, 1, 32'h400 + 32'(4 * i), 0);
      tick();
      check("fill no drop", s_drop, 1'b0);
    end
    set_in(1, 1, 1, 32'h410, 0);
    tick();
    check("full drop", s_drop, 1'b1);
    set_in(0, 0, 0, 0, 0);
    tick();
    check("idle after drop", s_drop, 1'b0);
    set_in(1, 1, 1, 32'h414, 1);
    tick();
    check("full+drain accept", s_drop, 1'b0);
    check("full+drain wren", s_wren, 1'b1);
    check("full+drain widx", s_idx, hash(32'h400));
    exp_order = '{hash(32'h404), hash(32'h408), hash(32'h40C), hash(32'h414)};
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 0, 0, 1);
      tick();
      if (s_wren) begin
        if (nwr < 4) check($sformatf("drain order %0d", nwr), s_idx, exp_order[nwr]);
        nwr++;
      end
    end
    check("drain count", 32'(nwr), 32'd4);

    // Reset with pending entries discards them.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 2, 32'h500 + 32'(4 * i), 0);
      tick();
    end
    set_in(0, 0, 0, 0, 1);
    reset = 1'b1;
    tick();
    check("reset wren", s_wren, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 1);
      tick();
      check("post-reset no write", s_wren, 1'b0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      BranchM    = 1'($urandom_range(0, 1));
      PCSrcM     = 1'($urandom_range(0, 1));
      BPDirPredM = 2'($urandom_range(0, 3));
      PCM        = 32'h1000 | (32'($urandom_range(0, 5)) << 2) |
                   (32'($urandom_range(0, 1)) << 11) | (32'($urandom_range(0, 1)) << 1);
      PCNextF    = 32'h2000 | (32'($urandom_range(0, 5)) << 2) |
                   (32'($urandom_range(0, 1)) << 11) | (32'($urandom_range(0, 1)) << 1);
      PHTRdDataF = 2'($urandom_range(0, 3));
      PHTWrReady = ($urandom_range(0, 9) < 4);
      StallM     = ($urandom_range(0, 9) == 0);
      FlushM     = ($urandom_range(0, 9) == 0);
      StallF     = ($urandom_range(0, 4) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
